// File: rtl/op_issue_queue_pkg.sv
// Shared types and widths for the per-core operation issue queue.
package op_issue_queue_pkg;

    localparam int unsigned OPERAND_W = 8;
    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned RESULT_W  = 16;

    // Core opcode set; the queue carries it through without decoding it.
    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        STORE = 3'd1,
        ADD   = 3'd2,
        SUB   = 3'd3,
        MUL   = 3'd4,
        AND   = 3'd5,
        OR    = 3'd6,
        XOR   = 3'd7
    } opcode;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } issue_state_t;

    typedef struct packed {
        opcode                op;
        logic [OPERAND_W-1:0] a;
        logic [OPERAND_W-1:0] b;
        logic [ADDR_W-1:0]    addr;
        logic [OPERAND_W-1:0] data;
    } issue_entry_t;

endpackage

// File: rtl/op_issue_queue_issue_fifo.sv
// Circular buffer of pending issue entries with registered occupancy flags.
module issue_fifo
    import op_issue_queue_pkg::*;
#(
    parameter int unsigned  DEPTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  issue_entry_t     push_entry,
    input  logic             pop,
    output issue_entry_t     head_c,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    issue_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CNT_W-1:0] count_next;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_c  = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; a simultaneous pair cancels out.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Pointers, count and flags; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // Entry storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/op_issue_queue.sv
// Per-core front end: queues ops, issues one at a time, captures results or times out.
module op_issue_queue
    import op_issue_queue_pkg::*;
#(
    parameter int unsigned  DEPTH   = 8,
    parameter int unsigned  TIMEOUT = 64,
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  opcode            instr_op,
    input  logic [7:0]       instr_a,
    input  logic [7:0]       instr_b,
    input  logic [11:0]      instr_addr,
    input  logic [7:0]       instr_data,
    output logic             start_op,
    output opcode            op_sel,
    output logic [7:0]       A,
    output logic [7:0]       B,
    output logic [11:0]      address_in,
    output logic [7:0]       data_in,
    input  logic             end_op,
    input  logic [15:0]      result,
    output logic             wb_valid,
    output opcode            wb_op,
    output logic [15:0]      wb_result,
    output logic             wb_err,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT);

    issue_state_t     state;
    issue_state_t     state_next;
    logic [TMR_W-1:0] timer;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             timer_clr;
    logic             timer_inc;
    logic             cap_done;
    logic             cap_abort;
    issue_entry_t     in_entry;
    issue_entry_t     head_entry;

    // full is the registered form of count == DEPTH, so ready depends only on state.
    assign instr_ready = !fifo_full;
    assign push        = instr_valid && instr_ready;
    assign in_entry    = '{op: instr_op, a: instr_a, b: instr_b, addr: instr_addr, data: instr_data};

    issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (in_entry),
        .pop        (pop),
        .head_c     (head_entry),
        .count      (count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus pop/capture/timer strobes.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        timer_clr  = 1'b0;
        timer_inc  = 1'b0;
        cap_done   = 1'b0;
        cap_abort  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                timer_clr  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (end_op) begin
                    cap_done   = 1'b1;
                    state_next = WB;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    cap_abort  = 1'b1;
                    state_next = WB;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            WB: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Completion timer, restarted on every issue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            timer <= '0;
        end else if (timer_clr) begin
            timer <= '0;
        end else if (timer_inc) begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Strobes follow the next state so they line up with ISSUE/WB cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            start_op <= 1'b0;
            wb_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            start_op <= (state_next == ISSUE);
            wb_valid <= (state_next == WB);
            busy     <= (state_next != IDLE);
        end
    end

    // Operand registers: loaded on pop, held until the next op is popped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_sel     <= LOAD;
            A          <= '0;
            B          <= '0;
            address_in <= '0;
            data_in    <= '0;
        end else if (pop) begin
            op_sel     <= head_entry.op;
            A          <= head_entry.a;
            B          <= head_entry.b;
            address_in <= head_entry.addr;
            data_in    <= head_entry.data;
        end
    end

    // Writeback registers: updated on completion or abort, held otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_op     <= LOAD;
            wb_result <= '0;
            wb_err    <= 1'b0;
        end else if (cap_done) begin
            wb_op     <= op_sel;
            wb_result <= result;
            wb_err    <= 1'b0;
        end else if (cap_abort) begin
            wb_op     <= op_sel;
            wb_result <= '0;
            wb_err    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_op_issue_queue.sv
`timescale 1ns/1ps
// Scoreboard bench for op_issue_queue driven by a behavioural core model.
module tb_op_issue_queue;
    import op_issue_queue_pkg::*;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    typedef struct {
        opcode       op;
        logic [15:0] res;
        logic        err;
        int          cyc;
    } wb_exp_t;

    logic             clk         = 1'b0;
    logic             rst         = 1'b0;
    logic             instr_valid = 1'b0;
    logic             instr_ready;
    opcode            instr_op    = LOAD;
    logic [7:0]       instr_a     = '0;
    logic [7:0]       instr_b     = '0;
    logic [11:0]      instr_addr  = '0;
    logic [7:0]       instr_data  = '0;
    logic             start_op;
    opcode            op_sel;
    logic [7:0]       A;
    logic [7:0]       B;
    logic [11:0]      address_in;
    logic [7:0]       data_in;
    logic             end_op      = 1'b0;
    logic [15:0]      result      = '0;
    logic             wb_valid;
    opcode            wb_op;
    logic [15:0]      wb_result;
    logic             wb_err;
    logic [CNT_W-1:0] count;
    logic             busy;

    op_issue_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_a(instr_a), .instr_b(instr_b), .instr_addr(instr_addr), .instr_data(instr_data),
        .start_op(start_op), .op_sel(op_sel), .A(A), .B(B),
        .address_in(address_in), .data_in(data_in),
        .end_op(end_op), .result(result),
        .wb_valid(wb_valid), .wb_op(wb_op), .wb_result(wb_result), .wb_err(wb_err),
        .count(count), .busy(busy)
    );

    // Scoreboard state
    issue_entry_t exp_issue [$];
    wb_exp_t      exp_wb [$];
    logic [7:0]   mem [4096];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           acc_cnt = 0;
    int           iss_cnt = 0;
    int           wb_seen = 0;
    int           err_seen = 0;
    int           end_at = -1;
    int           last_start = -1;
    int           core_lat = 2;
    bit           outstanding = 0;
    bit           period_chk = 0;
    bit           rand_core = 0;
    bit           hang_next = 0;
    bit           spur_issue = 0;
    bit           spur_idle = 0;
    bit           in_reset = 1;
    bit           saw_full = 0;
    issue_entry_t cur;
    logic [15:0]  pend_res = '0;
    logic [15:0]  last_res = '0;
    opcode        last_op = LOAD;
    logic         last_err = 1'b0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endfunction

    function automatic void bound_expired(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endfunction

    // What the core is expected to return for an op, from the ISA meaning.
    function automatic logic [15:0] core_result(input issue_entry_t e);
        case (e.op)
            LOAD:    return {8'h00, mem[e.addr]};
            STORE:   return 16'h0000;
            ADD:     return 16'(e.a) + 16'(e.b);
            SUB:     return 16'(e.a) - 16'(e.b);
            MUL:     return 16'(e.a) * 16'(e.b);
            AND:     return {8'h00, e.a & e.b};
            OR:      return {8'h00, e.a | e.b};
            default: return {8'h00, e.a ^ e.b};
        endcase
    endfunction

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Core model: checks issue order and operand hold, drives end_op, tracks occupancy.
    initial forever begin
        int  lat;
        bit  hang;
        @(negedge clk);
        end_op = 1'b0;
        if (in_reset) begin
            outstanding = 0;
            iss_cnt     = 0;
            end_at      = -1;
            continue;
        end
        if (start_op) begin
            chk("no_overlap", 64'(outstanding), 64'(0));
            iss_cnt++;
            chk("issue_expected", 64'(exp_issue.size() != 0), 64'(1));
            if (exp_issue.size() != 0) begin
                cur = exp_issue.pop_front();
                chk("issue_operands", 64'({op_sel, A, B, address_in, data_in}),
                    64'({cur.op, cur.a, cur.b, cur.addr, cur.data}));
                if (period_chk && last_start >= 0) begin
                    chk("issue_period", 64'(cyc - last_start), 64'(core_lat + 2));
                end
                last_start  = cyc;
                outstanding = 1;
                lat  = rand_core ? int'($urandom_range(1, 6)) : core_lat;
                hang = hang_next || (rand_core && $urandom_range(0, 19) == 0);
                hang_next = 0;
                if (hang) begin
                    end_at = -1;
                    exp_wb.push_back('{op: cur.op, res: 16'h0000, err: 1'b1, cyc: cyc + int'(TIMEOUT) + 1});
                end else begin
                    pend_res = core_result(cur);
                    if (cur.op == STORE) mem[cur.addr] = cur.data;
                    end_at = cyc + lat;
                    exp_wb.push_back('{op: cur.op, res: pend_res, err: 1'b0, cyc: cyc + lat + 1});
                end
            end
            if (spur_issue) begin
                end_op     = 1'b1;
                result     = 16'hDEAD;
                spur_issue = 0;
            end
        end else if (outstanding) begin
            if (!wb_valid) begin
                chk("operand_hold", 64'({op_sel, A, B, address_in, data_in}),
                    64'({cur.op, cur.a, cur.b, cur.addr, cur.data}));
            end else begin
                outstanding = 0;
            end
            if (cyc == end_at) begin
                end_op = 1'b1;
                result = pend_res;
                end_at = -1;
            end
        end else if (spur_idle) begin
            end_op    = 1'b1;
            result    = 16'hBEEF;
            spur_idle = 0;
        end
        chk("count", 64'(count), 64'(acc_cnt - iss_cnt));
        chk("instr_ready", 64'(instr_ready), 64'((acc_cnt - iss_cnt) < int'(DEPTH)));
        if (count == CNT_W'(DEPTH)) saw_full = 1;
    end

    // Writeback monitor: pops the scoreboard on every wb_valid.
    initial forever begin
        wb_exp_t w;
        @(negedge clk);
        if (in_reset) begin
            exp_wb.delete();
            continue;
        end
        if (wb_valid) begin
            wb_seen++;
            if (wb_err) err_seen++;
            last_res = wb_result;
            last_op  = wb_op;
            last_err = wb_err;
            chk("wb_expected", 64'(exp_wb.size() != 0), 64'(1));
            if (exp_wb.size() != 0) begin
                w = exp_wb.pop_front();
                chk("wb_op", 64'(wb_op), 64'(w.op));
                chk("wb_result", 64'(wb_result), 64'(w.res));
                chk("wb_err", 64'(wb_err), 64'(w.err));
                chk("wb_cycle", 64'(cyc), 64'(w.cyc));
            end
        end
    end

    // Called at a negedge; leaves instr_valid high so ops can stream back to back.
    task automatic push_op(input opcode op, input logic [7:0] a, input logic [7:0] b,
                           input logic [11:0] addr, input logic [7:0] data);
        int guard;
        guard       = 0;
        instr_valid = 1'b1;
        instr_op    = op;
        instr_a     = a;
        instr_b     = b;
        instr_addr  = addr;
        instr_data  = data;
        while (!instr_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 500) begin
                bound_expired("push_ready");
                instr_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        acc_cnt++;
        exp_issue.push_back('{op: op, a: a, b: b, addr: addr, data: data});
        @(negedge clk);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        instr_valid = 1'b0;
        while (!(exp_issue.size() == 0 && exp_wb.size() == 0 && !outstanding && !busy && count == '0)) begin
            @(negedge clk);
            n++;
            if (n > bound) begin
                bound_expired("wait_idle");
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_zero();
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_start_op", 64'(start_op), 64'(0));
        chk("rst_wb_valid", 64'(wb_valid), 64'(0));
        chk("rst_operands", 64'({op_sel, A, B, address_in, data_in}), 64'(0));
        chk("rst_wb_regs", 64'({wb_op, wb_result, wb_err}), 64'(0));
        chk("rst_instr_ready", 64'(instr_ready), 64'(1));
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int gap;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        // Power-on reset
        in_reset = 1;
        rst      = 1'b0;
        repeat (3) @(negedge clk);
        check_zero();
        rst = 1'b1;
        @(negedge clk);
        in_reset = 0;

        // Single ALU op with a core answering three cycles after start_op
        core_lat = 3;
        base     = wb_seen;
        push_op(ADD, 8'd12, 8'd10, 12'h000, 8'h00);
        wait_idle(300);
        chk("alu_wb_count", 64'(wb_seen - base), 64'(1));
        chk("alu_result", 64'(last_res), 64'(22));
        chk("alu_op", 64'(last_op), 64'(ADD));
        chk("alu_err", 64'(last_err), 64'(0));
        chk("alu_busy", 64'(busy), 64'(0));

        // Back-to-back fill: producer always valid, fast core, fixed 4-cycle issue period
        core_lat   = 2;
        last_start = -1;
        period_chk = 1;
        saw_full   = 0;
        for (int i = 0; i < 12; i++) begin
            push_op(opcode'(3'($urandom_range(2, 7))), 8'($urandom), 8'($urandom),
                    12'($urandom), 8'($urandom));
        end
        wait_idle(500);
        period_chk = 0;
        chk("fill_reached_full", 64'(saw_full), 64'(1));

        // Store then load to the same address
        core_lat = 4;
        push_op(STORE, 8'h11, 8'h22, 12'hA5C, 8'h3C);
        push_op(LOAD, 8'h33, 8'h44, 12'hA5C, 8'h00);
        wait_idle(300);
        chk("load_result", 64'(last_res), 64'(16'h003C));
        chk("load_op", 64'(last_op), 64'(LOAD));

        // Timeout on a hung op, then a normal op behind it
        core_lat  = 2;
        base      = err_seen;
        hang_next = 1;
        push_op(SUB, 8'd50, 8'd8, 12'h000, 8'h00);
        push_op(ADD, 8'd1, 8'd2, 12'h000, 8'h00);
        wait_idle(500);
        chk("timeout_err_count", 64'(err_seen - base), 64'(1));
        chk("after_timeout_result", 64'(last_res), 64'(3));
        chk("after_timeout_err", 64'(last_err), 64'(0));

        // Spurious end_op while idle, then during the issue cycle
        base      = wb_seen;
        spur_idle = 1;
        repeat (4) @(negedge clk);
        chk("spur_idle_busy", 64'(busy), 64'(0));
        chk("spur_idle_no_wb", 64'(wb_seen - base), 64'(0));
        core_lat   = 3;
        spur_issue = 1;
        push_op(MUL, 8'd7, 8'd9, 12'h000, 8'h00);
        wait_idle(300);
        chk("spur_issue_wb_count", 64'(wb_seen - base), 64'(1));
        chk("spur_issue_result", 64'(last_res), 64'(63));

        // Reset with one op waiting on the core and three queued
        core_lat = 40;
        base     = wb_seen;
        for (int i = 0; i < 4; i++) begin
            push_op(ADD, 8'(i), 8'd1, 12'h000, 8'h00);
        end
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_count", 64'(count), 64'(3));
        chk("pre_reset_busy", 64'(busy), 64'(1));
        in_reset = 1;
        rst      = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_zero();
        acc_cnt = 0;
        exp_issue.delete();
        @(negedge clk);
        in_reset = 0;
        repeat (6) @(negedge clk);
        chk("reset_no_wb", 64'(wb_seen - base), 64'(0));
        chk("reset_idle_busy", 64'(busy), 64'(0));
        core_lat = 2;
        push_op(XOR, 8'hF0, 8'h3C, 12'h000, 8'h00);
        wait_idle(300);
        chk("post_reset_wb_count", 64'(wb_seen - base), 64'(1));
        chk("post_reset_result", 64'(last_res), 64'(16'h00CC));

        // Randomised traffic with random core latency and occasional hangs
        rand_core = 1;
        for (int i = 0; i < 40; i++) begin
            gap = int'($urandom_range(0, 3));
            if (gap != 0) begin
                instr_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            push_op(opcode'(3'($urandom_range(0, 7))), 8'($urandom), 8'($urandom),
                    12'($urandom_range(0, 15)), 8'($urandom));
        end
        wait_idle(8000);
        rand_core = 0;
        chk("final_busy", 64'(busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
